// File: rtl/hangman_game_fsm.sv
// Hangman game control: holds the secret word, takes letter guesses, scans one position per cycle.
// Optional HANGMAN_REPEAT_PENALTY_EN: a repeated letter costs a wrong guess instead of being ignored.
module hangman_game_fsm #(
    parameter int WORD_LEN  = 5,
    parameter int MAX_WRONG = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  word_load,
    input  logic [5*WORD_LEN-1:0] word_data,
    input  logic                  guess_valid,
    input  logic [4:0]            guess_letter,
    output logic                  guess_ready,
    output logic [3:0]            state,
    output logic [WORD_LEN-1:0]   revealed,
    output logic [2:0]            wrong_count,
    output logic [25:0]           letter_used
);

    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic [2:0] {
        PH_START,
        PH_IDLE,
        PH_SCAN,
        PH_RESOLVE,
        PH_WIN,
        PH_LOST
    } phase_e;

    phase_e                phase_q, phase_d;
    logic [5*WORD_LEN-1:0] word_q, word_d;
    logic [WORD_LEN-1:0]   revealed_q, revealed_d;
    logic [2:0]            wrong_count_q, wrong_count_d;
    logic [25:0]           letter_used_q, letter_used_d;
    logic [4:0]            guess_q, guess_d;
    logic                  hit_q, hit_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [5*WORD_LEN-1:0] word_src;
    logic [WORD_LEN-1:0]   blank_mask;
    logic [4:0]            cur_letter;

    // A load in the same cycle as start must be the word the new game uses.
    always_comb begin
        word_src   = word_load ? word_data : word_q;
        blank_mask = '0;
        for (int i = 0; i < WORD_LEN; i++)
            blank_mask[i] = (word_src[5*i +: 5] >= 5'd26);
        cur_letter = word_q[5*int'(idx_q) +: 5];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= PH_START;
            word_q        <= '0;
            revealed_q    <= '0;
            wrong_count_q <= '0;
            letter_used_q <= '0;
            guess_q       <= '0;
            hit_q         <= 1'b0;
            idx_q         <= '0;
        end else begin
            phase_q       <= phase_d;
            word_q        <= word_d;
            revealed_q    <= revealed_d;
            wrong_count_q <= wrong_count_d;
            letter_used_q <= letter_used_d;
            guess_q       <= guess_d;
            hit_q         <= hit_d;
            idx_q         <= idx_d;
        end
    end

    always_comb begin
        phase_d       = phase_q;
        word_d        = word_q;
        revealed_d    = revealed_q;
        wrong_count_d = wrong_count_q;
        letter_used_d = letter_used_q;
        guess_d       = guess_q;
        hit_d         = hit_q;
        idx_d         = idx_q;

        case (phase_q)
            PH_START: begin
                if (word_load)
                    word_d = word_data;
                if (start) begin
                    revealed_d    = blank_mask;
                    wrong_count_d = '0;
                    letter_used_d = '0;
                    phase_d       = PH_IDLE;
                end
            end
            PH_IDLE: begin
                if (guess_valid && guess_letter <= 5'd25) begin
                    if (letter_used_q[guess_letter]) begin
`ifdef HANGMAN_REPEAT_PENALTY_EN
                        hit_d   = 1'b0;
                        phase_d = PH_RESOLVE;
`endif
                    end else begin
                        letter_used_d[guess_letter] = 1'b1;
                        guess_d = guess_letter;
                        hit_d   = 1'b0;
                        idx_d   = '0;
                        phase_d = PH_SCAN;
                    end
                end
            end
            PH_SCAN: begin
                if (cur_letter == guess_q) begin
                    revealed_d[idx_q] = 1'b1;
                    hit_d             = 1'b1;
                end
                if (idx_q == IDX_W'(WORD_LEN - 1))
                    phase_d = PH_RESOLVE;
                else
                    idx_d = idx_q + 1'b1;
            end
            PH_RESOLVE: begin
                if (!hit_q) begin
                    if (wrong_count_q < 3'(MAX_WRONG))
                        wrong_count_d = wrong_count_q + 3'd1;
                    if (wrong_count_q + 3'd1 >= 3'(MAX_WRONG))
                        phase_d = PH_LOST;
                    else
                        phase_d = PH_IDLE;
                end else if (&revealed_q) begin
                    phase_d = PH_WIN;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_WIN, PH_LOST: begin
                if (start)
                    phase_d = PH_START;
            end
            default: phase_d = PH_START;
        endcase
    end

    always_comb begin
        case (phase_q)
            PH_START: state = 4'd0;
            PH_WIN:   state = 4'd2;
            PH_LOST:  state = 4'd3;
            default:  state = 4'd1;
        endcase
    end

    assign guess_ready = (phase_q == PH_IDLE);
    assign revealed    = revealed_q;
    assign wrong_count = wrong_count_q;
    assign letter_used = letter_used_q;

endmodule

// File: tb/tb_hangman_game_fsm.sv
// Directed bench for hangman_game_fsm (WORD_LEN=5, MAX_WRONG=6); inputs change and outputs are sampled on negedge.
module tb_hangman_game_fsm;

    localparam int WL = 5;

    logic          clk = 1'b0;
    logic          reset, start, word_load, guess_valid;
    logic [5*WL-1:0] word_data;
    logic [4:0]    guess_letter;
    logic          guess_ready;
    logic [3:0]    state;
    logic [WL-1:0] revealed;
    logic [2:0]    wrong_count;
    logic [25:0]   letter_used;

    int n_checks = 0;
    int n_fails  = 0;

    hangman_game_fsm #(.WORD_LEN(WL), .MAX_WRONG(6)) dut (
        .clk(clk), .reset(reset), .start(start), .word_load(word_load),
        .word_data(word_data), .guess_valid(guess_valid), .guess_letter(guess_letter),
        .guess_ready(guess_ready), .state(state), .revealed(revealed),
        .wrong_count(wrong_count), .letter_used(letter_used)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer a guess for one cycle; returns in the cycle after the accepting edge.
    task automatic guess(input logic [4:0] l);
        guess_valid = 1'b1; guess_letter = l;
        step();
        guess_valid = 1'b0;
    endtask

    // Full scan + resolve: ready low for WL+1 cycles, then back in IDLE.
    task automatic guess_full(input string tag, input logic [4:0] l);
        guess(l);
        for (int i = 0; i < WL + 1; i++) begin
            chk({tag, "_busy"}, 32'(guess_ready), 32'd0);
            step();
        end
    endtask

    function automatic logic [5*WL-1:0] mk(input logic [4:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    logic [2:0] rep_wc;

    initial begin
        reset = 1'b1; start = 1'b0; word_load = 1'b0; guess_valid = 1'b0;
        word_data = '0; guess_letter = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(guess_ready), 32'd0);
        chk("rst_revealed", 32'(revealed), 32'd0);
        chk("rst_wrong", 32'(wrong_count), 32'd0);
        chk("rst_used", 32'(letter_used), 32'd0);

        // Load HELLO together with start: the load must take effect first.
        word_data = mk(5'd7, 5'd4, 5'd11, 5'd11, 5'd14);
        word_load = 1'b1; start = 1'b1;
        step();
        word_load = 1'b0; start = 1'b0;
        chk("go_state", 32'(state), 32'd1);
        chk("go_revealed", 32'(revealed), 32'd0);
        chk("go_ready", 32'(guess_ready), 32'd1);

        guess_full("L", 5'd11);
        chk("L_ready", 32'(guess_ready), 32'd1);
        chk("L_revealed", 32'(revealed), 32'b01100);
        chk("L_wrong", 32'(wrong_count), 32'd0);
        chk("L_used", 32'(letter_used[11]), 32'd1);

        guess_full("H", 5'd7);
        chk("H_revealed", 32'(revealed), 32'b01101);
        guess_full("E", 5'd4);
        chk("E_revealed", 32'(revealed), 32'b01111);

        // Illegal code: consumed in one cycle with no effect.
        guess(5'd27);
        chk("ill_ready", 32'(guess_ready), 32'd1);
        chk("ill_used", 32'(letter_used), 32'h0000_0890);

        // Repeated E.
        guess(5'd4);
`ifdef HANGMAN_REPEAT_PENALTY_EN
        chk("rep_ready_low", 32'(guess_ready), 32'd0);
        step();
        rep_wc = 3'd1;
`else
        rep_wc = 3'd0;
`endif
        chk("rep_ready", 32'(guess_ready), 32'd1);
        chk("rep_wrong", 32'(wrong_count), 32'(rep_wc));
        chk("rep_state", 32'(state), 32'd1);

        guess_full("O", 5'd14);
        chk("win_state", 32'(state), 32'd2);
        chk("win_revealed", 32'(revealed), 32'b11111);
        chk("win_used", 32'(letter_used), 32'h0000_4890);

        // Guesses after WIN change nothing.
        guess(5'd0);
        step(); step();
        chk("frz_state", 32'(state), 32'd2);
        chk("frz_ready", 32'(guess_ready), 32'd0);
        chk("frz_used", 32'(letter_used), 32'h0000_4890);
        chk("frz_wrong", 32'(wrong_count), 32'(rep_wc));

        // Back to START, then a new game on the kept word.
        start = 1'b1; step(); start = 1'b0;
        chk("back_state", 32'(state), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        chk("g2_state", 32'(state), 32'd1);
        chk("g2_revealed", 32'(revealed), 32'd0);
        chk("g2_used", 32'(letter_used), 32'd0);
        chk("g2_wrong", 32'(wrong_count), 32'd0);
        // start while in the game is ignored
        start = 1'b1; step(); start = 1'b0;
        chk("ign_start", 32'(state), 32'd1);

        for (int i = 0; i < 6; i++) begin
            guess_full("miss", 5'(25 - i));
            chk("miss_wrong", 32'(wrong_count), 32'(i + 1));
            chk("miss_state", 32'(state), (i == 5) ? 32'd3 : 32'd1);
        end
        chk("lost_ready", 32'(guess_ready), 32'd0);
        guess(5'd19);
        step();
        chk("lost_sat", 32'(wrong_count), 32'd6);
        start = 1'b1; step(); start = 1'b0;
        chk("lost_back", 32'(state), 32'd0);

        // Word with a blank in position 2: that position is pre-revealed.
        word_data = mk(5'd7, 5'd4, 5'd31, 5'd11, 5'd14);
        word_load = 1'b1; step(); word_load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("blk_revealed", 32'(revealed), 32'b00100);

        // Reset in the middle of a scan.
        guess(5'd11);
        chk("scan_busy", 32'(guess_ready), 32'd0);
        step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_state", 32'(state), 32'd0);
        chk("mid_ready", 32'(guess_ready), 32'd0);
        chk("mid_revealed", 32'(revealed), 32'd0);
        chk("mid_wrong", 32'(wrong_count), 32'd0);
        chk("mid_used", 32'(letter_used), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hangman_game_fsm.md
# hangman_game_fsm

Game-control stage for the Hangman design. It holds the secret word, accepts letter guesses over a valid/ready handshake, scans the word one position per cycle, tracks revealed positions and wrong guesses, and produces the 4-bit game `state` consumed directly by the VGA display stage. It sits between keyboard/letter decoding upstream and the display downstream.

## Interface
- `WORD_LEN`, default 5: letters in the secret word (1–16).
- `MAX_WRONG`, default 6: wrong guesses that end the game (1–7).
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: single-cycle pulse; starts a game or returns to START.
- `word_load` input, 1 bit: latch `word_data`; honoured only in START.
- `word_data` input, 5*WORD_LEN bits: letter codes, position 0 in bits [4:0]. 0–25 = A–Z, 31 = blank, 26–30 = illegal, treated as blank.
- `guess_valid` input, 1 bit: guess offered.
- `guess_letter` input, 5 bits: guess code, 0–25.
- `guess_ready` output, 1 bit: FSM can accept a guess.
- `state` output, 4 bits: 0 START, 1 INGAME, 2 WINGAME, 3 LOSTGAME.
- `revealed` output, WORD_LEN bits: bit i set means position i is shown.
- `wrong_count` output, 3 bits: wrong guesses so far.
- `letter_used` output, 26 bits: bit n set means letter n has been guessed.

## Operation
- Internal phases: START, IDLE, SCAN, RESOLVE, WIN, LOST. `state` reads 1 during IDLE, SCAN and RESOLVE.
- START:
  - `word_load` latches the word register.
  - `start` clears `revealed`, `wrong_count` and `letter_used`, then enters IDLE.
  - When entering IDLE, positions holding code 26–31 are set in `revealed`.
  - If `start` and `word_load` arrive in the same cycle, the load applies first and the game uses the new word.
- IDLE:
  - `guess_ready` is 1.
  - A guess is accepted on `guess_valid & guess_ready`.
  - Letter code > 25: guess consumed, no state change.
  - Letter already in `letter_used`: guess consumed, no scan, FSM stays in IDLE (see Configuration).
  - Otherwise: set the `letter_used` bit, register the letter, clear the hit flag, set the position index to 0, enter SCAN.
- SCAN: one position per cycle. On a match, set `revealed[idx]` and the hit flag. After index WORD_LEN-1, go to RESOLVE.
- RESOLVE:
  - No hit: `wrong_count` += 1. If the new value equals MAX_WRONG, go to LOST.
  - Hit and `revealed` all ones: go to WIN.
  - Otherwise: return to IDLE.
  - Win and lose cannot occur together in the same resolve.
- WIN / LOST: outputs are frozen and guesses are ignored. `start` returns to START; the word register is kept.
- `start` in IDLE, SCAN or RESOLVE is ignored.
- `wrong_count` saturates at MAX_WRONG and never wraps.

## Timing
- Reset values: `state`=0, `guess_ready`=0, `revealed`=0, `wrong_count`=0, `letter_used`=0, word register=0, internal phase START.
- `guess_ready` is combinational from the phase: 1 only in IDLE.
- Fresh guess: accepted at edge T. `guess_ready` is low for cycles T+1 through T+WORD_LEN+1, then high again at T+WORD_LEN+2.
- `revealed` bits update during SCAN, at the edge after the matching position is examined.
- `wrong_count`, `state`=2 and `state`=3 update at the RESOLVE edge.
- Repeat or illegal guess: consumed in one cycle; `guess_ready` stays high.
- Reset asserted mid-SCAN: next edge returns to reset values, and the partially scanned guess is discarded.

## Configuration
- `HANGMAN_REPEAT_PENALTY_EN` defined: a repeated letter goes to RESOLVE with no hit. This costs one wrong guess and can cause LOST. `guess_ready` is low for exactly 1 cycle.
- Not defined: a repeated letter is consumed with no effect.

## Test plan
- Reset, then load "HELLO" (7,4,11,11,14) and pulse `start` -> `state`=1, `revealed`=00000, `guess_ready`=1.
- Guess L (11) -> `guess_ready` low for 6 cycles; then `revealed`=01100 (bits 2,3), `wrong_count`=0, `letter_used[11]`=1.
- Guesses H, E, L, O -> after the last RESOLVE, `state`=2; further guesses leave all outputs unchanged.
- Guesses Z, Y, X, W, V, U on MAX_WRONG=6 -> `wrong_count` counts 1..6, `state`=3 at the sixth RESOLVE; `start` -> `state`=0.
- Guess E twice -> without the macro, `wrong_count` stays 0 and the second guess is consumed in 1 cycle. With `HANGMAN_REPEAT_PENALTY_EN` defined, `wrong_count`=1.
- Word "HE" + blank + "LO" (blank code 31 in position 2), `start` -> `revealed`=00100. Then assert `reset` mid-SCAN -> all outputs return to zero on the next edge.
